// File: rtl/npu_pkg.sv
// +--------------------------------------------------------------------------+
// | npu_pkg : shared image geometry, window constants and fetch FSM states   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package npu_pkg;

  localparam int IMG_W    = 30;
  localparam int IMG_H    = 30;
  localparam int K        = 3;
  localparam int ADDR_W   = 10;
  localparam int N_TAPS   = K * K;
  localparam int WIN_SPAN = IMG_W - K + 1;
  localparam int N_WIN    = (IMG_W - K + 1) ** 2;
  localparam int WIN_ROWS = N_WIN / WIN_SPAN;
  localparam int PIX_W    = $clog2(IMG_W * IMG_H);
  localparam int POS_W    = 5;
  localparam int TAP_W    = 4;
  localparam int WIN_BITS = 8 * N_TAPS;

  // Taps run row-major inside the window: tap t sits at (t / K, t % K).
  localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(N_TAPS - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_PRESENT = 3'd3,
    ST_DONE    = 3'd4
  } fetch_state_t;

  // True for the rightmost tap of a window row, where the pointer jumps to the next image row.
  function automatic logic tap_row_end(input logic [TAP_W-1:0] tap);
    logic r;
    r = 1'b0;
    for (int i = 1; i <= K; i++) begin
      if (tap == TAP_W'(i * K - 1)) r = 1'b1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/img_tap_addr_gen.sv
// +--------------------------------------------------------------------------+
// | img_tap_addr_gen : incremental pixel pointer -> bank select and address  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module img_tap_addr_gen
  import npu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              step_tap,
  input  logic              step_win,
  input  logic [POS_W-1:0]  col,
  input  logic [TAP_W-1:0]  tap,
  output logic [1:0]        bank,
  output logic [ADDR_W-1:0] addr
);

  logic [PIX_W-1:0] base_q, base_d;
  logic [PIX_W-1:0] pix_q, pix_d;

  // The pointer parks on the last tap so the address holds outside ISSUE.
  always_comb begin
    base_d = base_q;
    pix_d  = pix_q;
    if (clear) begin
      base_d = '0;
      pix_d  = '0;
    end else if (step_win) begin
      base_d = base_q + ((col == POS_W'(WIN_SPAN - 1)) ? PIX_W'(K) : PIX_W'(1));
      pix_d  = base_d;
    end else if (step_tap && (tap != TAP_LAST)) begin
      pix_d = pix_q + (tap_row_end(tap) ? PIX_W'(IMG_W - K + 1) : PIX_W'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      base_q <= '0;
      pix_q  <= '0;
    end else begin
      base_q <= base_d;
      pix_q  <= pix_d;
    end
  end

  assign bank = pix_q[1:0];
  assign addr = ADDR_W'(pix_q >> 2);

endmodule

`default_nettype wire

// File: rtl/image_window_fetch.sv
// +--------------------------------------------------------------------------+
// | image_window_fetch : streams every KxK window of the image to the conv   |
// | engine. Optional IMG_FETCH_STALL_CNT_EN adds stall_count. Rev 1.0        |
// +--------------------------------------------------------------------------+
`default_nettype none

module image_window_fetch
  import npu_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic [ADDR_W-1:0]   image_ram_addr_b,
  input  logic [7:0]          q_image0,
  input  logic [7:0]          q_image1,
  input  logic [7:0]          q_image2,
  input  logic [7:0]          q_image3,
  output logic                win_valid,
  input  logic                win_ready,
  output logic [WIN_BITS-1:0] window_data,
  output logic [POS_W-1:0]    win_row,
  output logic [POS_W-1:0]    win_col,
  output logic                busy,
  output logic                done
`ifdef IMG_FETCH_STALL_CNT_EN
  ,
  output logic [31:0]         stall_count
`endif
);

  fetch_state_t        state_q, state_d;
  logic [POS_W-1:0]    row_q, row_d, col_q, col_d;
  logic [TAP_W-1:0]    tap_q, tap_d, cap_tap_q, cap_tap_d;
  logic [1:0]          cap_bank_q, cap_bank_d;
  logic                cap_en_q, cap_en_d;
  logic [WIN_BITS-1:0] window_data_q, window_data_d;
  logic                win_valid_q, win_valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                gen_clear, gen_step_tap, gen_step_win;
  logic [1:0]          gen_bank;
  logic [7:0]          bank_byte;
  logic                accept, last_win;
`ifdef IMG_FETCH_STALL_CNT_EN
  logic [31:0]         stall_count_q, stall_count_d;
`endif

  img_tap_addr_gen u_addr_gen (
    .clk      (clk),
    .reset    (reset),
    .clear    (gen_clear),
    .step_tap (gen_step_tap),
    .step_win (gen_step_win),
    .col      (col_q),
    .tap      (tap_q),
    .bank     (gen_bank),
    .addr     (image_ram_addr_b)
  );

  assign accept   = win_valid_q && win_ready;
  assign last_win = (row_q == POS_W'(WIN_ROWS - 1)) && (col_q == POS_W'(WIN_SPAN - 1));

  always_comb begin
    case (cap_bank_q)
      2'd0:    bank_byte = q_image0;
      2'd1:    bank_byte = q_image1;
      2'd2:    bank_byte = q_image2;
      default: bank_byte = q_image3;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    tap_d        = tap_q;
    win_valid_d  = win_valid_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    gen_clear    = 1'b0;
    gen_step_tap = 1'b0;
    gen_step_win = 1'b0;
    // Read data lags the address by one cycle, so bank and tap travel with it.
    cap_en_d     = (state_q == ST_ISSUE);
    cap_tap_d    = tap_q;
    cap_bank_d   = gen_bank;

    window_data_d = window_data_q;
    if (cap_en_q) begin
      for (int t = 0; t < N_TAPS; t++) begin
        if (cap_tap_q == TAP_W'(t)) window_data_d[WIN_BITS-1-8*t -: 8] = bank_byte;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_ISSUE;
          row_d     = '0;
          col_d     = '0;
          tap_d     = '0;
          busy_d    = 1'b1;
          gen_clear = 1'b1;
        end
      end
      ST_ISSUE: begin
        gen_step_tap = 1'b1;
        if (tap_q == TAP_LAST) begin
          state_d = ST_CAPTURE;
          tap_d   = '0;
        end else begin
          tap_d = tap_q + TAP_W'(1);
        end
      end
      ST_CAPTURE: begin
        state_d     = ST_PRESENT;
        win_valid_d = 1'b1;
      end
      ST_PRESENT: begin
        if (accept) begin
          win_valid_d = 1'b0;
          if (last_win) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d      = ST_ISSUE;
            gen_step_win = 1'b1;
            if (col_q == POS_W'(WIN_SPAN - 1)) begin
              col_d = '0;
              row_d = row_q + POS_W'(1);
            end else begin
              col_d = col_q + POS_W'(1);
            end
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

`ifdef IMG_FETCH_STALL_CNT_EN
    stall_count_d = stall_count_q;
    if ((state_q == ST_IDLE) && start) begin
      stall_count_d = '0;
    end else if (win_valid_q && !win_ready && (stall_count_q != 32'hFFFF_FFFF)) begin
      stall_count_d = stall_count_q + 32'd1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      row_q         <= '0;
      col_q         <= '0;
      tap_q         <= '0;
      cap_tap_q     <= '0;
      cap_bank_q    <= '0;
      cap_en_q      <= 1'b0;
      window_data_q <= '0;
      win_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
`ifdef IMG_FETCH_STALL_CNT_EN
      stall_count_q <= '0;
`endif
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      col_q         <= col_d;
      tap_q         <= tap_d;
      cap_tap_q     <= cap_tap_d;
      cap_bank_q    <= cap_bank_d;
      cap_en_q      <= cap_en_d;
      window_data_q <= window_data_d;
      win_valid_q   <= win_valid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
`ifdef IMG_FETCH_STALL_CNT_EN
      stall_count_q <= stall_count_d;
`endif
    end
  end

  assign win_valid   = win_valid_q;
  assign window_data = window_data_q;
  assign win_row     = row_q;
  assign win_col     = col_q;
  assign busy        = busy_q;
  assign done        = done_q;
`ifdef IMG_FETCH_STALL_CNT_EN
  assign stall_count = stall_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_image_window_fetch.sv
// +--------------------------------------------------------------------------+
// | tb_image_window_fetch : randomized frames against a window model         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_image_window_fetch;
  import npu_pkg::*;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              win_ready = 1'b0;
  logic [ADDR_W-1:0] image_ram_addr_b;
  logic [7:0]        q_image0, q_image1, q_image2, q_image3;
  logic              win_valid, busy, done;
  logic [71:0]       window_data;
  logic [4:0]        win_row, win_col;
`ifdef IMG_FETCH_STALL_CNT_EN
  logic [31:0]       stall_count;
`endif

  int          n_vec = 0;
  int          n_bad = 0;
  logic [7:0]  img     [IMG_W*IMG_H];
  logic [71:0] got_win [N_WIN];

  always #5 clk = ~clk;

  image_window_fetch dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .image_ram_addr_b (image_ram_addr_b),
    .q_image0         (q_image0),
    .q_image1         (q_image1),
    .q_image2         (q_image2),
    .q_image3         (q_image3),
    .win_valid        (win_valid),
    .win_ready        (win_ready),
    .window_data      (window_data),
    .win_row          (win_row),
    .win_col          (win_col),
    .busy             (busy),
    .done             (done)
`ifdef IMG_FETCH_STALL_CNT_EN
    ,
    .stall_count      (stall_count)
`endif
  );

  function automatic logic [7:0] pix_at(input int p);
    if (p >= 0 && p < IMG_W*IMG_H) return img[p];
    return 8'h00;
  endfunction

  // Four banks, byte p in bank p%4 at address p/4, one-cycle read latency.
  always @(posedge clk) begin
    q_image0 <= pix_at(4*int'(image_ram_addr_b) + 0);
    q_image1 <= pix_at(4*int'(image_ram_addr_b) + 1);
    q_image2 <= pix_at(4*int'(image_ram_addr_b) + 2);
    q_image3 <= pix_at(4*int'(image_ram_addr_b) + 3);
  end

  function automatic logic [71:0] exp_win(input int r, input int c);
    logic [71:0] w;
    w = '0;
    for (int ki = 0; ki < K; ki++)
      for (int kj = 0; kj < K; kj++)
        w[71-8*(ki*K+kj) -: 8] = pix_at((r+ki)*IMG_W + c + kj);
    return w;
  endfunction

  task automatic check_val(input string tag, input logic [71:0] got, input logic [71:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  // One frame: start, then consume windows with random ready; optional reset abort.
  task automatic run_frame(input int ready_pct, input bit poke_start, input bit do_stall,
                           input int abort_win);
    int  n, cyc, first_valid, last_acc, done_cyc, stall_left, r, c;
    bit  aborted, quiet_bad;
    logic [31:0] exp_stall;
    n = 0; cyc = 0; first_valid = -1; last_acc = -1; done_cyc = -1;
    stall_left = 20; aborted = 0; exp_stall = '0;
    win_ready = (ready_pct >= 100);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; cyc = 1;
    check_val("busy_rise", busy, 1);
    check_val("addr_first", image_ram_addr_b, 0);
    while (done_cyc < 0 && !aborted && cyc < 40*N_WIN) begin
      r = n / WIN_SPAN;
      c = n % WIN_SPAN;
      if (abort_win > 0 && n == abort_win && cyc == last_acc + 3) begin
        reset = 1'b1; win_ready = 1'b0; start = 1'b0;
        @(negedge clk); reset = 1'b0;
        check_val("abort_valid", win_valid, 0);
        check_val("abort_busy", busy, 0);
        check_val("abort_done", done, 0);
        quiet_bad = 0;
        for (int i = 0; i < 30; i++) begin
          @(negedge clk);
          if (done || win_valid || busy) quiet_bad = 1;
        end
        check_val("abort_quiet", quiet_bad, 0);
        aborted = 1;
      end else begin
        if (done) begin
          done_cyc = cyc;
          check_val("done_after_last", cyc, last_acc + 1);
          check_val("accepts_at_done", n, N_WIN);
        end
        if (win_valid) begin
          if (first_valid < 0) first_valid = cyc;
          check_val("win_data", window_data, exp_win(r, c));
          check_val("win_row", win_row, r);
          check_val("win_col", win_col, c);
          check_val("busy_hi", busy, 1);
          check_val("addr_hold", image_ram_addr_b, ((r+K-1)*IMG_W + c + K - 1) >> 2);
        end
        if (do_stall && win_valid && n == 5 && stall_left > 0) begin
          win_ready = 1'b0;
          stall_left--;
        end else begin
          win_ready = ($urandom_range(99) < ready_pct);
        end
        start = poke_start && ($urandom_range(15) == 0);
        if (win_valid && !win_ready) exp_stall++;
        if (win_valid && win_ready) begin
          if (ready_pct >= 100 && n > 0) check_val("win_period", cyc - last_acc, 11);
          got_win[n] = window_data;
          last_acc = cyc;
          n++;
        end
        cyc++;
        @(negedge clk);
      end
    end
    start = 1'b0;
    win_ready = 1'b0;
    if (!aborted) begin
      check_val("done_seen", done_cyc >= 0, 1);
      check_val("accept_count", n, N_WIN);
      check_val("first_latency", first_valid, 11);
      check_val("done_width", done, 0);
      check_val("busy_after_done", busy, 0);
`ifdef IMG_FETCH_STALL_CNT_EN
      check_val("stall_count", stall_count, exp_stall);
`else
      if (exp_stall > 32'd0 && do_stall) check_val("stall_seen", exp_stall >= 32'd20, 1);
`endif
    end
  endtask

  initial begin
    for (int p = 0; p < IMG_W*IMG_H; p++) img[p] = 8'(p % 256);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_val("rst_valid", win_valid, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_data", window_data, 0);
    check_val("rst_row", win_row, 0);
    check_val("rst_col", win_col, 0);
    check_val("rst_addr", image_ram_addr_b, 0);
`ifdef IMG_FETCH_STALL_CNT_EN
    check_val("rst_stall", stall_count, 0);
`endif

    run_frame(100, 1'b0, 1'b0, 0);
    check_val("win_0_0", got_win[0], 72'h00_01_02_1E_1F_20_3C_3D_3E);
    check_val("win_1_0", got_win[WIN_SPAN], 72'h1E_1F_20_3C_3D_3E_5A_5B_5C);
    check_val("win_27_27", got_win[N_WIN-1], 72'h45_46_47_63_64_65_81_82_83);

    run_frame(100, 1'b0, 1'b0, 100);

    for (int p = 0; p < IMG_W*IMG_H; p++) img[p] = 8'($urandom_range(255));
    run_frame(75, 1'b1, 1'b1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
